// File: rtl/easiroc_sim_pkg.sv
// Shared defaults and helpers for the EASIROC read-chain simulation model.
// Helpers work on fixed-width containers so callers zero-extend into them.
package easiroc_sim_pkg;

    localparam int unsigned ADC_W_DEF = 12;
    localparam int unsigned N_CH_DEF  = 32;
    localparam int unsigned MAX_L     = 256;

    // base + sig + noise, clamped to [0, 2^w-1]
    function automatic logic [31:0] sat_add(input logic [31:0]        base,
                                            input logic [31:0]        sig,
                                            input logic signed [3:0]  noise,
                                            input int unsigned        w);
        logic signed [35:0] sum;
        logic signed [35:0] ceil_v;
        sum    = $signed({4'b0, base}) + $signed({4'b0, sig}) + 36'(noise);
        ceil_v = (36'sd1 <<< w) - 36'sd1;
        if (sum < 36'sd0)
            return 32'd0;
        if (sum > ceil_v)
            return 32'(ceil_v);
        return 32'(sum);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_L-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_L; i++)
            c += {31'd0, v[i]};
        return c;
    endfunction

    function automatic int unsigned onehot_index(input logic [MAX_L-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_L; i++)
            if (v[i])
                idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/easiroc_amp_gen.sv
// Hold snapshot, event counter and per-channel amplitude codes; registered, 1 cycle after decode.
// No backpressure. EASIROC_READ_NOISE_EN adds LFSR noise of -4..+3 before saturation.
module easiroc_amp_gen
    import easiroc_sim_pkg::*;
#(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned ADC_W     = ADC_W_DEF,
    parameter int unsigned EVT_W     = 8,
    parameter int unsigned PED_HG    = 200,
    parameter int unsigned PED_LG    = 100,
    parameter int unsigned SLOPE_HG  = 16,
    parameter int unsigned EVT_STEP  = 4,
    parameter int unsigned LG_SHIFT  = 3,
    parameter int unsigned IDLE_CODE = 0
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             hold_fall,
    input  logic             hold_rise,
    input  logic             ch_valid,
    input  logic [IDX_W-1:0] ch_index,
    input  logic             sel_err,
    output logic [ADC_W-1:0] adc_hg,
    output logic [ADC_W-1:0] adc_lg,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int unsigned SW = ADC_W + EVT_W + 8;

    logic             held_q, held_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [EVT_W-1:0] snap_q, snap_d;
    logic [ADC_W-1:0] hg_q, hg_d;
    logic [ADC_W-1:0] lg_q, lg_d;
    logic [SW-1:0]    sig;
    logic signed [3:0] noise;

`ifdef EASIROC_READ_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= lfsr_d;
    end

    assign noise = $signed({1'b0, lfsr_q[2:0]}) - 4'sd4;
`else
    assign noise = 4'sd0;
`endif

    always_comb begin
        held_d = held_q;
        evt_d  = evt_q;
        snap_d = snap_q;
        if (hold_fall) begin
            snap_d = evt_q;
            held_d = 1'b1;
        end
        // Only a rise that ends an actual hold counts, so the first cycle after reset is harmless.
        if (hold_rise && held_q) begin
            held_d = 1'b0;
            evt_d  = evt_q + 1'b1;
        end
    end

    always_comb begin
        sig  = SW'(ch_index) * SW'(SLOPE_HG) + SW'(snap_q) * SW'(EVT_STEP);
        hg_d = ADC_W'(IDLE_CODE);
        lg_d = ADC_W'(IDLE_CODE);
        if (ch_valid && !sel_err) begin
            if (held_q) begin
                hg_d = ADC_W'(sat_add(32'(PED_HG), 32'(sig), noise, ADC_W));
                lg_d = ADC_W'(sat_add(32'(PED_LG), 32'(sig >> LG_SHIFT), noise, ADC_W));
            end else begin
                hg_d = ADC_W'(sat_add(32'(PED_HG), 32'd0, noise, ADC_W));
                lg_d = ADC_W'(sat_add(32'(PED_LG), 32'd0, noise, ADC_W));
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            evt_q  <= '0;
            snap_q <= '0;
            hg_q   <= '0;
            lg_q   <= '0;
        end else begin
            held_q <= held_d;
            evt_q  <= evt_d;
            snap_q <= snap_d;
            hg_q   <= hg_d;
            lg_q   <= lg_d;
        end
    end

    assign adc_hg  = hg_q;
    assign adc_lg  = lg_q;
    assign evt_cnt = evt_q;

endmodule

// File: rtl/easiroc_read_chain_model.sv
// EASIROC read-register daisy chain model: token shift, one-hot decode, analog codes to the ADC models.
// Token/decode 1 cycle after a sampled clk_read rise, codes 1 cycle later. No backpressure.
// EASIROC_READ_NOISE_EN enables LFSR noise on the analog codes (inside easiroc_amp_gen).
module easiroc_read_chain_model
    import easiroc_sim_pkg::*;
#(
    parameter int unsigned N_CHIP    = 2,
    parameter int unsigned N_CH      = N_CH_DEF,
    parameter int unsigned ADC_W     = ADC_W_DEF,
    parameter int unsigned EVT_W     = 8,
    parameter int unsigned PED_HG    = 200,
    parameter int unsigned PED_LG    = 100,
    parameter int unsigned SLOPE_HG  = 16,
    parameter int unsigned EVT_STEP  = 4,
    parameter int unsigned LG_SHIFT  = 3,
    parameter int unsigned IDLE_CODE = 0
) (
    input  logic                              clk_50M,
    input  logic                              rst_n,
    input  logic                              clk_read,
    input  logic                              rstb_read,
    input  logic                              srin_read,
    input  logic                              holdb,
    output logic                              srout_read,
    output logic [ADC_W-1:0]                  adc_hg,
    output logic [ADC_W-1:0]                  adc_lg,
    output logic                              ch_valid,
    output logic [$clog2(N_CHIP*N_CH)-1:0]    ch_index,
    output logic [EVT_W-1:0]                  evt_cnt,
    output logic                              token_err
);

    localparam int unsigned L     = N_CHIP * N_CH;
    localparam int unsigned IDX_W = $clog2(L);

    logic         clk_read_q, clk_read_d;
    logic         holdb_q, holdb_d;
    logic [L-1:0] token_q, token_d;
    logic         srout_q, srout_d;
    logic         token_err_q, token_err_d;

    logic         rise;
    logic         hold_fall;
    logic         hold_rise;
    logic         multi;
    int unsigned  pc;

    assign rise      = clk_read & ~clk_read_q;
    assign hold_fall = ~holdb & holdb_q;
    assign hold_rise = holdb & ~holdb_q;

    always_comb begin
        pc       = popcount(MAX_L'(token_q));
        ch_valid = (pc == 1);
        multi    = (pc > 1);
        ch_index = ch_valid ? IDX_W'(onehot_index(MAX_L'(token_q))) : '0;
    end

    // Read-register reset wins over a simultaneous shift.
    always_comb begin
        clk_read_d  = clk_read;
        holdb_d     = holdb;
        token_d     = token_q;
        token_err_d = token_err_q | multi;
        if (!rstb_read) begin
            token_d     = '0;
            token_err_d = 1'b0;
        end else if (rise) begin
            token_d = {token_q[L-2:0], srin_read};
        end
        srout_d = token_d[L-1];
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            clk_read_q  <= 1'b0;
            holdb_q     <= 1'b0;
            token_q     <= '0;
            srout_q     <= 1'b0;
            token_err_q <= 1'b0;
        end else begin
            clk_read_q  <= clk_read_d;
            holdb_q     <= holdb_d;
            token_q     <= token_d;
            srout_q     <= srout_d;
            token_err_q <= token_err_d;
        end
    end

    assign srout_read = srout_q;
    assign token_err  = token_err_q | multi;

    easiroc_amp_gen #(
        .IDX_W     (IDX_W),
        .ADC_W     (ADC_W),
        .EVT_W     (EVT_W),
        .PED_HG    (PED_HG),
        .PED_LG    (PED_LG),
        .SLOPE_HG  (SLOPE_HG),
        .EVT_STEP  (EVT_STEP),
        .LG_SHIFT  (LG_SHIFT),
        .IDLE_CODE (IDLE_CODE)
    ) u_amp (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .hold_fall (hold_fall),
        .hold_rise (hold_rise),
        .ch_valid  (ch_valid),
        .ch_index  (ch_index),
        .sel_err   (token_err),
        .adc_hg    (adc_hg),
        .adc_lg    (adc_lg),
        .evt_cnt   (evt_cnt)
    );

endmodule

// File: tb/tb_easiroc_read_chain_model.sv
// Bench for easiroc_read_chain_model: vector table, directed corner sequences and random stimulus
// against a token-position / event-count reference model; a second instance uses SLOPE_HG=100.
module tb_easiroc_read_chain_model;

    localparam int L = 64;

`ifdef EASIROC_READ_NOISE_EN
    localparam int TOL = 4;
`else
    localparam int TOL = 0;
`endif

    logic clk_50M = 1'b0;
    logic rst_n = 1'b1;
    logic clk_read, rstb_read, srin_read, holdb;

    logic        srout_read, ch_valid, token_err;
    logic [11:0] adc_hg, adc_lg;
    logic [5:0]  ch_index;
    logic [7:0]  evt_cnt;

    logic        s_srout, s_valid, s_err;
    logic [11:0] s_hg, s_lg;
    logic [5:0]  s_idx;
    logic [7:0]  s_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_50M = ~clk_50M;

    easiroc_read_chain_model dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .clk_read(clk_read), .rstb_read(rstb_read),
        .srin_read(srin_read), .holdb(holdb), .srout_read(srout_read), .adc_hg(adc_hg),
        .adc_lg(adc_lg), .ch_valid(ch_valid), .ch_index(ch_index), .evt_cnt(evt_cnt),
        .token_err(token_err)
    );

    easiroc_read_chain_model #(.SLOPE_HG(100)) dut_sat (
        .clk_50M(clk_50M), .rst_n(rst_n), .clk_read(clk_read), .rstb_read(rstb_read),
        .srin_read(srin_read), .holdb(holdb), .srout_read(s_srout), .adc_hg(s_hg),
        .adc_lg(s_lg), .ch_valid(s_valid), .ch_index(s_idx), .evt_cnt(s_evt),
        .token_err(s_err)
    );

    // Reference model: positions of the token bits, sticky error, hold state, event counts.
    int m_pos[$];
    bit m_err, m_held, m_clk_prev, m_holdb_prev, m_srout;
    int m_evt, m_snap;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_code(input string name, input int act, input int exp);
        n_tests++;
        if (act - exp > TOL || exp - act > TOL) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, TOL);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    function automatic int exp_code(input int slope, input bit lg);
        int sig;
        if (m_pos.size() != 1 || m_err) return 0;
        sig = m_held ? m_pos[0] * slope + m_snap * 4 : 0;
        return lg ? clamp(100 + (sig >> 3)) : clamp(200 + sig);
    endfunction

    task automatic model_reset();
        m_pos.delete();
        m_err = 0; m_held = 0; m_clk_prev = 0; m_holdb_prev = 0; m_srout = 0;
        m_evt = 0; m_snap = 0;
    endtask

    task automatic model_update(input bit c, input bit r, input bit s, input bit h);
        int nq[$];
        bit multi_pre;
        multi_pre = (m_pos.size() > 1);
        if (!r) begin
            m_pos.delete();
            m_err = 0;
        end else begin
            m_err = m_err | multi_pre;
            if (c && !m_clk_prev) begin
                foreach (m_pos[k])
                    if (m_pos[k] + 1 < L) nq.push_back(m_pos[k] + 1);
                if (s) nq.push_back(0);
                m_pos = nq;
            end
        end
        m_err = m_err | (m_pos.size() > 1);
        m_srout = 0;
        foreach (m_pos[k]) if (m_pos[k] == L - 1) m_srout = 1;
        if (!h && m_holdb_prev) begin
            m_snap = m_evt;
            m_held = 1;
        end
        if (h && !m_holdb_prev && m_held) begin
            m_held = 0;
            m_evt = (m_evt + 1) % 256;
        end
        m_clk_prev = c;
        m_holdb_prev = h;
    endtask

    task automatic step(input bit c, input bit r, input bit s, input bit h);
        int e_hg, e_lg, e_shg, e_slg, e_idx;
        clk_read = c; rstb_read = r; srin_read = s; holdb = h;
        e_hg  = exp_code(16, 0);
        e_lg  = exp_code(16, 1);
        e_shg = exp_code(100, 0);
        e_slg = exp_code(100, 1);
        model_update(c, r, s, h);
        @(posedge clk_50M); #1;
        e_idx = (m_pos.size() == 1) ? m_pos[0] : 0;
        chk("ch_valid", int'(ch_valid), int'(m_pos.size() == 1));
        chk("ch_index", int'(ch_index), e_idx);
        chk("token_err", int'(token_err), int'(m_err));
        chk("srout_read", int'(srout_read), int'(m_srout));
        chk("evt_cnt", int'(evt_cnt), m_evt);
        chk_code("adc_hg", int'(adc_hg), e_hg);
        chk_code("adc_lg", int'(adc_lg), e_lg);
        chk_code("sat_adc_hg", int'(s_hg), e_shg);
        chk_code("sat_adc_lg", int'(s_lg), e_slg);
        chk("sat_ctrl", {int'(s_valid), int'(s_idx), int'(s_err), int'(s_srout), int'(s_evt)} == 
            {int'(ch_valid), int'(ch_index), int'(token_err), int'(srout_read), int'(evt_cnt)} ? 1 : 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_adc_hg"}, int'(adc_hg), 0);
        chk({tag, "_adc_lg"}, int'(adc_lg), 0);
        chk({tag, "_ch_valid"}, int'(ch_valid), 0);
        chk({tag, "_ch_index"}, int'(ch_index), 0);
        chk({tag, "_evt_cnt"}, int'(evt_cnt), 0);
        chk({tag, "_token_err"}, int'(token_err), 0);
        chk({tag, "_srout"}, int'(srout_read), 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        for (int k = 0; k < n; k++) begin
            clk_read = k[0]; rstb_read = 1'b1; srin_read = 1'b1; holdb = 1'b1;
            @(posedge clk_50M); #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit c, r, s;
        int v, idx, err, hg;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 0, 200};
        tbl[3]  = '{1, 1, 0, 1, 1, 0, 200};
        tbl[4]  = '{0, 1, 0, 1, 1, 0, 200};
        tbl[5]  = '{1, 1, 1, 0, 0, 1, 200};
        tbl[6]  = '{0, 1, 0, 0, 0, 1, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 1, 0, 0, 200};

        clk_read = 1'b0; rstb_read = 1'b1; srin_read = 1'b0; holdb = 1'b1;
        #2;
        do_reset(6);

        // Token walk, double token error and rstb_read priority, holdb idle high.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].c, tbl[i].r, tbl[i].s, 1'b1);
            chk($sformatf("tbl%0d_valid", i), int'(ch_valid), tbl[i].v);
            chk($sformatf("tbl%0d_index", i), int'(ch_index), tbl[i].idx);
            chk($sformatf("tbl%0d_err", i), int'(token_err), tbl[i].err);
            chk_code($sformatf("tbl%0d_hg", i), int'(adc_hg), tbl[i].hg);
        end

        // Full 64-stage scan while held at event 0.
        step(0, 0, 0, 0);
        for (int i = 0; i <= 64; i++) begin
            step(1, 1, i == 0, 0);
            step(0, 1, 0, 0);
            chk($sformatf("scan%0d_srout", i), int'(srout_read), int'(i == 63));
            if (i < 64) begin
                chk($sformatf("scan%0d_index", i), int'(ch_index), i);
                chk_code($sformatf("scan%0d_hg", i), int'(adc_hg), 200 + 16 * i);
                chk_code($sformatf("scan%0d_sat_hg", i), int'(s_hg), (200 + 100 * i > 4095) ? 4095 : 200 + 100 * i);
            end else begin
                chk("scan_end_valid", int'(ch_valid), 0);
            end
        end
        chk("scan_evt", int'(evt_cnt), 0);

        // Abort mid-readout with the token in flight.
        step(1, 1, 1, 0);
        do_reset(4);

        // Three hold pulses, then hold and select channel 5.
        step(0, 1, 0, 1);
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 0, 0);
            step(0, 1, 0, 1);
        end
        chk("evt_after_3", int'(evt_cnt), 3);
        step(0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            step(1, 1, r == 0, 0);
            step(0, 1, 0, 0);
        end
        chk("ch5_index", int'(ch_index), 5);
        chk_code("ch5_hg", int'(adc_hg), 292);
        chk_code("ch5_lg", int'(adc_lg), 111);
        chk_code("ch5_sat_hg", int'(s_hg), 712);
        chk_code("ch5_sat_lg", int'(s_lg), 164);
        step(0, 1, 0, 1);
        chk("evt_after_4", int'(evt_cnt), 4);

        // Event counter wrap after 256 completed holds.
        for (int p = 0; p < 252; p++) begin
            step(0, 1, 0, 0);
            step(0, 1, 0, 1);
        end
        chk("evt_wrap", int'(evt_cnt), 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit c, r, s, h;
            c = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 31) != 0);
            s = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 7) == 0) ? ~holdb : holdb;
            step(c, r, s, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
